axi_lite_io_slave: RTL and testbench
====================================

// Module: axi_lite_io_slave
// PURPOSE
//  AXI4-Lite responder on the core's S_AXI_* in/out port: the far end of core IO accesses.
//  Bridges register accesses to byte streams from/to the serial (UART) RX/TX blocks.
//  Holds an RX FIFO (core reads 0x0) and a TX FIFO (core writes 0x4); 0x8 is status.
//  Full/empty back-pressure is applied by withholding BVALID/RVALID, so core IO just stalls.
// PARAMETERS
//  FIFO_DEPTH_LOG2  4  log2 of RX and TX FIFO depth (16 entries each)
// PORTS
//  CLK            in   1   clock; all logic on posedge
//  RST            in   1   synchronous reset, active-high
//  S_AXI_AWADDR   in   4   write address
//  S_AXI_AWVALID  in   1   write address valid
//  S_AXI_AWREADY  out  1   write address accepted
//  S_AXI_WDATA    in   32  write data; only [7:0] used
//  S_AXI_WSTB     in   4   byte strobes; push only if WSTB[0]=1
//  S_AXI_WVALID   in   1   write data valid
//  S_AXI_WREADY   out  1   write data accepted
//  S_AXI_BRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1   write response valid
//  S_AXI_BREADY   in   1   write response accepted
//  S_AXI_ARADDR   in   4   read address
//  S_AXI_ARVALID  in   1   read address valid
//  S_AXI_ARREADY  out  1   read address accepted
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1   read data valid
//  S_AXI_RREADY   in   1   read data accepted
//  RX_TDATA       in   8   byte from UART receiver
//  RX_TVALID      in   1   RX byte valid
//  RX_TREADY      out  1   = !rx_full
//  TX_TDATA       out  8   byte to UART transmitter (TX FIFO head)
//  TX_TVALID      out  1   = !tx_empty
//  TX_TREADY      in   1   transmitter took byte; pop TX FIFO
// BEHAVIOUR
//  Reset: all *READY/*VALID outputs 0, BRESP/RRESP/RDATA 0, both FIFOs empty, FSMs idle.
//   Reset mid-transaction abandons it; no response issued; FIFO contents lost.
//  Map: 0x0 RD pops RX (RDATA={24'b0,byte}); 0x4 WR pushes WDATA[7:0] to TX;
//   0x8 RD status {16'b0, rx_count[7:0], 6'b0, tx_full, rx_nonempty}.
//   Any other addr/direction: SLVERR, no side effect, RDATA=0, never stalls.
//  Write FSM W_IDLE -> W_EXEC -> W_RESP -> W_IDLE:
//   W_IDLE: AWREADY=!aw_held, WREADY=!w_held; AW and W captured independently, any order
//    or same cycle; go W_EXEC once both held.
//   W_EXEC: if 0x4 and tx_full, wait; else push (if WSTB[0]), BVALID<=1 -> W_RESP.
//   W_RESP: hold BVALID/BRESP until BREADY; then clear held flags -> W_IDLE.
//   Min latency: AW+W same cycle N -> BVALID at N+2. One write outstanding.
//  Read FSM R_IDLE -> (R_WAIT) -> R_RESP -> R_IDLE:
//   R_IDLE: ARREADY=1; on AR handshake at N: addr 0x0 and RX empty -> R_WAIT;
//    else RDATA/RRESP registered, pop if 0x0, RVALID=1 at N+1 -> R_RESP.
//   R_WAIT: ARREADY=0; when RX nonempty, pop into RDATA, RVALID<=1 -> R_RESP.
//   R_RESP: hold RVALID/RDATA until RREADY -> R_IDLE (ARREADY again next cycle).
//  Read and write FSMs are independent; same-cycle activity on both is legal.
//  FIFOs: circular, pointers FIFO_DEPTH_LOG2+1 bits (MSB distinguishes full vs empty).
//   Push+pop same cycle: both occur, count unchanged; full: push allowed only with
//   same-cycle pop (RX_TREADY stays !full, so no RX push in that case); empty: pop ignored.
//   Pointers wrap modulo depth with no bubble.
//   RX byte accepted when RX_TVALID&RX_TREADY; TX pop when TX_TVALID&TX_TREADY.
//  rx_count saturates display at 8 bits (depth <= 128 required).
// TESTING
//  AW=0x4,W=0x41,WSTB=1111 same cycle -> BVALID 2 cycles later, BRESP=00, TX_TDATA=0x41 TVALID=1.
//  RX_TDATA=0x5A pushed; AR=0x0 -> RVALID next cycle, RDATA=0x5A, RRESP=00; status bit0 then 0.
//  AR=0x0 with RX empty -> RVALID held 0; push 0x33 10 cycles later -> RVALID next cycle, RDATA=0x33.
//  Fill TX (16 writes, TX_TREADY=0); 17th write -> no BVALID; TX_TREADY=1 one cycle -> BVALID, 17th byte queued.
//  W before AW by 3 cycles -> WREADY drops after W; BVALID 2 cycles after AW handshake.
//  AW=0xC write and AR=0x4 read -> BRESP=10, RRESP=10, RDATA=0; RST mid-R_WAIT -> RVALID=0, FIFOs empty.

Source files
------------

// File: rtl/axi_lite_io_slave.sv
// rtl/axi_lite_io_slave.sv - AXI4-Lite responder bridging core IO accesses to UART RX/TX byte FIFOs
// 0x0 read pops RX, 0x4 write pushes TX, 0x8 read is status; full/empty stalls the response.

module axi_lite_io_slave #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [7:0]  RX_TDATA,
  input  logic        RX_TVALID,
  output logic        RX_TREADY,
  output logic [7:0]  TX_TDATA,
  output logic        TX_TVALID,
  input  logic        TX_TREADY
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, rx_count;
  logic          rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]    rx_head;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, tx_count;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  logic          aw_held, w_held, wstb0_q;
  logic [3:0]    awaddr_q;
  logic [7:0]    wdata_q;
  logic [1:0]    bresp_q;
  logic          aw_hs, w_hs, wr_is_tx, w_stall;

  logic          ar_hs;
  logic [31:0]   rdata_q, status_word;
  logic [1:0]    rresp_q;

  logic          unused_wbits;
  assign unused_wbits = ^{S_AXI_WDATA[31:8], S_AXI_WSTB[3:1]};

  // Pointers carry one extra bit so equal low bits can be told apart as full or empty.
  assign rx_count  = rx_wr_ptr - rx_rd_ptr;
  assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full   = (rx_count == PW'(DEPTH));
  assign rx_head   = rx_mem[rx_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign rx_push   = RX_TVALID && !rx_full && !RST;
  assign RX_TREADY = !rx_full && !RST;

  assign tx_count  = tx_wr_ptr - tx_rd_ptr;
  assign tx_empty  = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full   = (tx_count == PW'(DEPTH));
  assign TX_TDATA  = tx_mem[tx_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign TX_TVALID = !tx_empty && !RST;
  assign tx_pop    = TX_TVALID && TX_TREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= RX_TDATA;
        rx_wr_ptr <= rx_wr_ptr + PW'(1);
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wdata_q;
        tx_wr_ptr <= tx_wr_ptr + PW'(1);
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + PW'(1);
    end
  end

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_is_tx = (awaddr_q == 4'h4);
  // A full TX FIFO still takes the byte when the transmitter drains one in the same cycle.
  assign w_stall  = wr_is_tx && tx_full && !tx_pop;
  assign tx_push  = (w_state == W_EXEC) && !w_stall && wr_is_tx && wstb0_q;

  always_ff @(posedge CLK) begin
    if (RST) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_EXEC;
      W_EXEC:  if (!w_stall) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    if (!RST) begin
      S_AXI_AWREADY = (w_state == W_IDLE) && !aw_held;
      S_AXI_WREADY  = (w_state == W_IDLE) && !w_held;
      S_AXI_BVALID  = (w_state == W_RESP);
    end
  end
  assign S_AXI_BRESP = bresp_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstb0_q  <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA[7:0];
        wstb0_q <= S_AXI_WSTB[0];
      end
      if (w_state == W_EXEC && !w_stall)
        bresp_q <= wr_is_tx ? RESP_OKAY : RESP_SLVERR;
      if (w_state == W_RESP && S_AXI_BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign status_word = {16'b0, 8'(rx_count), 6'b0, tx_full, !rx_empty};
  assign rx_pop      = !rx_empty && !RST &&
                       ((r_state == R_IDLE && ar_hs && S_AXI_ARADDR == 4'h0) ||
                        (r_state == R_WAIT));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (S_AXI_ARADDR == 4'h0 && rx_empty) ? R_WAIT : R_RESP;
      R_WAIT:  if (!rx_empty) r_next = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    if (!RST) begin
      S_AXI_ARREADY = (r_state == R_IDLE);
      S_AXI_RVALID  = (r_state == R_RESP);
    end
  end
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (r_state == R_IDLE && ar_hs) begin
      case (S_AXI_ARADDR)
        4'h0: if (!rx_empty) begin
          rdata_q <= {24'b0, rx_head};
          rresp_q <= RESP_OKAY;
        end
        4'h8: begin
          rdata_q <= status_word;
          rresp_q <= RESP_OKAY;
        end
        default: begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      endcase
    end else if (r_state == R_WAIT && !rx_empty) begin
      rdata_q <= {24'b0, rx_head};
      rresp_q <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_lite_io_slave.sv
// tb/tb_axi_lite_io_slave.sv - randomized self-checking bench for axi_lite_io_slave
// A queue-based model of the two FIFOs supplies every expected value.

module tb_axi_lite_io_slave;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [7:0]  RX_TDATA;
  logic        RX_TVALID;
  logic        RX_TREADY;
  logic [7:0]  TX_TDATA;
  logic        TX_TVALID;
  logic        TX_TREADY;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 CLK = ~CLK;

  axi_lite_io_slave #(.FIFO_DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RST(RST),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTB(S_AXI_WSTB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .RX_TDATA(RX_TDATA), .RX_TVALID(RX_TVALID), .RX_TREADY(RX_TREADY),
    .TX_TDATA(TX_TDATA), .TX_TVALID(TX_TVALID), .TX_TREADY(TX_TREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    int s;
    s = (rx_q.size() << 8) | ((tx_q.size() == DEPTH ? 1 : 0) << 1) | (rx_q.size() != 0 ? 1 : 0);
    return 32'(s);
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [7:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_f, w_f;
    int cyc = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = {24'($urandom), data};
    S_AXI_WSTB   = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_WVALID  = !w_done && cyc >= w_dly;
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge CLK); #1;
      aw_done |= aw_f;
      w_done  |= w_f;
      cyc++;
      if (w_done && !aw_done) check("wready_low_after_w", 32'(S_AXI_WREADY), 0);
      if (aw_done && !w_done) check("awready_low_after_aw", 32'(S_AXI_AWREADY), 0);
    end
    S_AXI_AWVALID = 0;
    S_AXI_WVALID  = 0;
    check("aw_w_handshake", 32'(aw_done && w_done), 1);
    S_AXI_BREADY = 1;
    lat = 0;
    while (!S_AXI_BVALID && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("bvalid_seen", 32'(S_AXI_BVALID), 1);
    resp = S_AXI_BRESP;
    @(posedge CLK); #1;
    S_AXI_BREADY = 0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit done = 0;
    int cyc = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1;
    while (!done && cyc < 50) begin
      done = S_AXI_ARREADY;
      @(posedge CLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 0;
    check("ar_handshake", 32'(done), 1);
    S_AXI_RREADY = 1;
    lat = 0;
    while (!S_AXI_RVALID && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("rvalid_seen", 32'(S_AXI_RVALID), 1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge CLK); #1;
    S_AXI_RREADY = 0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    RX_TDATA  = b;
    RX_TVALID = 1;
    check("rx_tready", 32'(RX_TREADY), 32'(rx_q.size() < DEPTH));
    @(posedge CLK); #1;
    RX_TVALID = 0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  task automatic tx_pop();
    check("tx_tvalid", 32'(TX_TVALID), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("tx_tdata", 32'(TX_TDATA), 32'(tx_q[0]));
    TX_TREADY = 1;
    @(posedge CLK); #1;
    TX_TREADY = 0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    logic [1:0] r;
    int l;
    axi_read(4'h8, d, r, l);
    check(tag, d, status_exp());
    check("status_rresp", 32'(r), 0);
    check("status_latency", l, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r, wr;
    int l, wl;
    logic [7:0]  b;
    logic [3:0]  a;
    logic [31:0] exp_stat;

    RST = 1;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    RX_TDATA = 0; RX_TVALID = 0; TX_TREADY = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready", 32'(S_AXI_WREADY), 0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 0);
    check("rst_rx_tready", 32'(RX_TREADY), 0);
    check("rst_tx_tvalid", 32'(TX_TVALID), 0);
    check("rst_resps", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    RST = 0;
    @(posedge CLK); #1;
    check("idle_arready", 32'(S_AXI_ARREADY), 1);
    check("idle_awready", 32'(S_AXI_AWREADY), 1);
    check("idle_rx_tready", 32'(RX_TREADY), 1);

    axi_write(4'h4, 8'h41, 4'hf, 0, 0, wr, wl);
    check("wr41_bresp", 32'(wr), 0);
    check("wr41_latency", wl, 1);
    tx_q.push_back(8'h41);
    check("wr41_tx_tvalid", 32'(TX_TVALID), 1);
    check("wr41_tx_tdata", 32'(TX_TDATA), 32'h41);
    tx_pop();

    rx_push(8'h5a);
    read_status("status_one_rx");
    axi_read(4'h0, d, r, l);
    check("rd5a_rdata", d, 32'h5a);
    check("rd5a_rresp", 32'(r), 0);
    check("rd5a_latency", l, 0);
    void'(rx_q.pop_front());
    read_status("status_rx_empty");

    fork
      axi_read(4'h0, d, r, l);
      begin
        repeat (10) @(posedge CLK);
        #1;
        check("rwait_rvalid_low", 32'(S_AXI_RVALID), 0);
        check("rwait_arready_low", 32'(S_AXI_ARREADY), 0);
        rx_push(8'h33);
      end
    join
    check("rwait_rdata", d, {24'b0, rx_q.pop_front()});
    check("rwait_rresp", 32'(r), 0);
    check("rwait_latency_min", 32'(l >= 10), 1);

    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      axi_write(4'h4, b, 4'hf, 0, 0, wr, wl);
      check("fill_latency", wl, 1);
      tx_q.push_back(b);
    end
    read_status("status_tx_full");
    b = 8'($urandom);
    fork
      axi_write(4'h4, b, 4'hf, 0, 0, wr, wl);
      begin
        repeat (6) @(posedge CLK);
        #1;
        check("full_bvalid_held", 32'(S_AXI_BVALID), 0);
        tx_pop();
      end
    join
    check("full_bresp", 32'(wr), 0);
    tx_q.push_back(b);
    read_status("status_refilled");
    while (tx_q.size() != 0) tx_pop();

    axi_write(4'h4, 8'h77, 4'hf, 3, 0, wr, wl);
    check("w_first_latency", wl, 1);
    check("w_first_bresp", 32'(wr), 0);
    tx_q.push_back(8'h77);
    axi_write(4'h4, 8'h78, 4'hf, 0, 2, wr, wl);
    check("aw_first_latency", wl, 1);
    tx_q.push_back(8'h78);

    axi_write(4'hc, 8'h11, 4'hf, 0, 0, wr, wl);
    check("bad_wr_bresp", 32'(wr), 2);
    axi_read(4'h4, d, r, l);
    check("bad_rd_rresp", 32'(r), 2);
    check("bad_rd_rdata", d, 0);
    axi_write(4'h4, 8'h99, 4'he, 0, 0, wr, wl);
    check("nostrb_bresp", 32'(wr), 0);
    read_status("status_after_bad");

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1: rx_push(8'($urandom));
        2: if (rx_q.size() != 0) begin
          axi_read(4'h0, d, r, l);
          check("rnd_rx_rdata", d, {24'b0, rx_q.pop_front()});
          check("rnd_rx_latency", l, 0);
        end
        3: read_status("rnd_status");
        4, 5: if (tx_q.size() < DEPTH) begin
          b = 8'($urandom);
          a = 4'($urandom);
          axi_write(4'h4, b, a, $urandom_range(0, 2), $urandom_range(0, 2), wr, wl);
          check("rnd_wr_bresp", 32'(wr), 0);
          check("rnd_wr_latency", wl, 1);
          if (a[0]) tx_q.push_back(b);
        end
        6: tx_pop();
        7: begin
          a = 4'($urandom);
          if (a == 4'h4) a = 4'h5;
          axi_write(a, 8'($urandom), 4'hf, 0, $urandom_range(0, 1), wr, wl);
          check("rnd_bad_bresp", 32'(wr), 2);
          check("rnd_bad_wr_latency", wl, 1);
        end
        8: begin
          a = 4'($urandom);
          if (a == 4'h0 || a == 4'h8) a = 4'h4;
          axi_read(a, d, r, l);
          check("rnd_bad_rresp", 32'(r), 2);
          check("rnd_bad_rdata", d, 0);
        end
        default: if (tx_q.size() < DEPTH - 1) begin
          b = 8'($urandom);
          exp_stat = status_exp();
          fork
            axi_write(4'h4, b, 4'hf, 0, 0, wr, wl);
            axi_read(4'h8, d, r, l);
          join
          check("par_status", d, exp_stat);
          check("par_bresp", 32'(wr), 0);
          check("par_wr_latency", wl, 1);
          tx_q.push_back(b);
        end
      endcase
    end

    while (tx_q.size() != 0) tx_pop();
    tx_pop();
    while (rx_q.size() != 0) begin
      axi_read(4'h0, d, r, l);
      check("drain_rdata", d, {24'b0, rx_q.pop_front()});
    end
    read_status("status_drained");

    axi_write(4'h4, 8'h5c, 4'hf, 0, 0, wr, wl);
    tx_q.push_back(8'h5c);
    rx_push(8'h21);
    axi_read(4'h0, d, r, l);
    check("pre_rst_rdata", d, {24'b0, rx_q.pop_front()});
    S_AXI_ARADDR = 4'h0;
    S_AXI_ARVALID = 1;
    check("pre_wait_arready", 32'(S_AXI_ARREADY), 1);
    @(posedge CLK); #1;
    S_AXI_ARVALID = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("wait_rvalid_low", 32'(S_AXI_RVALID), 0);
    RST = 1;
    @(posedge CLK); #1;
    check("midrst_rvalid", 32'(S_AXI_RVALID), 0);
    RST = 0;
    rx_q.delete();
    tx_q.delete();
    @(posedge CLK); #1;
    check("postrst_rvalid", 32'(S_AXI_RVALID), 0);
    check("postrst_tx_tvalid", 32'(TX_TVALID), 0);
    check("postrst_arready", 32'(S_AXI_ARREADY), 1);
    read_status("postrst_status");
    rx_push(8'h99);
    axi_read(4'h0, d, r, l);
    check("postrst_rdata", d, {24'b0, rx_q.pop_front()});
    check("postrst_latency", l, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
